prog_mod_counter: RTL and testbench

//   Successor to the fixed mod-M counter: up/down counter with runtime-programmable modulus,

---
 rtl/prog_mod_counter_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/prog_mod_counter.sv | 98 +++++++++
 tb/tb_prog_mod_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_mod_counter_pkg.sv
// rtl/prog_mod_counter_pkg.sv - shared constants and helpers for the programmable-modulus counter family
package prog_mod_counter_pkg;

    // Direction encoding for the up input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2 for sizing counters from ratios; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0..ratio-1, never narrower than one bit
    function automatic int phase_width(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-P enable prescaler; tick marks the last phase (used when PROG_MOD_COUNTER_PRESCALE_EN is defined)
module tick_prescaler
    import prog_mod_counter_pkg::*;
#(
    parameter int P = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              PW   = phase_width(P);
    localparam logic [PW-1:0]   LAST = PW'(P - 1);

    logic [PW-1:0] phase;

    // Phase advances on en and returns to 0 after the last phase; clr restarts the cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    assign tick = en & (phase == LAST);

endmodule

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - up/down counter with programmable limit, load, boundary ticks and wrap pulse; optional prescaler via PROG_MOD_COUNTER_PRESCALE_EN
module prog_mod_counter
    import prog_mod_counter_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 10,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         lim_wr,
    input  logic [N-1:0] lim_val,
    output logic [N-1:0] count,
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    output logic         pre_tick,
`endif
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap
);

    localparam logic [N-1:0] LIM_RST = N'(M - 1);

    logic [N-1:0] limit;
    logic [N-1:0] count_nxt;
    logic         wrap_nxt;
    logic         pre_ok;
    logic         step;

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    tick_prescaler #(
        .P (P)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (en),
        .tick  (pre_ok)
    );

    assign pre_tick = pre_ok;
`else
    // Without the prescaler every enabled cycle is a step (a nonsensical P < 1 stalls it)
    assign pre_ok = (P >= 1);
`endif

    assign step = en & ~load & pre_ok;

    // Next count and wrap: load wins over a step; steps always use the current limit
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                if (count >= limit) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + N'(1);
                end
            end else begin
                if (count == '0) begin
                    count_nxt = limit;
                    wrap_nxt  = 1'b1;
                end else if (count > limit) begin
                    count_nxt = limit;
                end else begin
                    count_nxt = count - N'(1);
                end
            end
        end
    end

    // Count, wrap and limit registers; a new limit takes effect from the following edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            limit <= LIM_RST;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            if (lim_wr) begin
                limit <= lim_val;
            end
        end
    end

    assign max_tick = (count == limit);
    assign min_tick = (count == '0);

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - randomized and directed bench for prog_mod_counter against an integer reference model
module tb_prog_mod_counter;

    localparam int N = 4;
    localparam int M = 10;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         lim_wr = 1'b0;
    logic [N-1:0] lim_val = '0;
    logic [N-1:0] count;
    logic         max_tick;
    logic         min_tick;
    logic         wrap;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    logic         pre_tick;
`endif

    int vectors = 0;
    int miscompares = 0;

    int m_count = 0;
    int m_limit = M - 1;
    int m_wrap = 0;
    int m_pre = 0;
    int wrap_seen = 0;

    prog_mod_counter #(
        .N (N),
        .M (M),
        .P (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .lim_wr   (lim_wr),
        .lim_val  (lim_val),
        .count    (count),
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
        .pre_tick (pre_tick),
`endif
        .max_tick (max_tick),
        .min_tick (min_tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, in integer arithmetic
    task automatic model_edge(input bit r, input bit ld, input int lv, input bit e,
                              input bit u, input bit lw, input int lmv);
        bit stp;
        if (!r) begin
            m_count = 0;
            m_limit = M - 1;
            m_wrap  = 0;
            m_pre   = 0;
            return;
        end
        stp    = 1'b0;
        m_wrap = 0;
        if (ld) begin
            m_count = lv;
            m_pre   = 0;
        end else begin
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
            if (e) begin
                if (m_pre == P - 1) begin
                    stp   = 1'b1;
                    m_pre = 0;
                end else begin
                    m_pre++;
                end
            end
`else
            stp = e;
`endif
            if (stp) begin
                if (u) begin
                    if (m_count > m_limit) begin
                        m_count = 0;
                        m_wrap  = 1;
                    end else begin
                        m_count = (m_count + 1) % (m_limit + 1);
                        m_wrap  = (m_count == 0);
                    end
                end else begin
                    if (m_count == 0) begin
                        m_count = m_limit;
                        m_wrap  = 1;
                    end else if (m_count > m_limit) begin
                        m_count = m_limit;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end
        end
        if (lw) m_limit = lmv;
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge
    task automatic cyc(input bit r, input bit ld, input int lv, input bit e,
                       input bit u, input bit lw, input int lmv);
        int lvm;
        int lmm;
        lvm      = lv & ((1 << N) - 1);
        lmm      = lmv & ((1 << N) - 1);
        reset    = r;
        load     = ld;
        load_val = lvm[N-1:0];
        en       = e;
        up       = u;
        lim_wr   = lw;
        lim_val  = lmm[N-1:0];
        #1;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
        check("pre_tick", 32'(pre_tick), 32'(e && (m_pre == P - 1)));
`endif
        @(posedge clk);
        model_edge(r, ld, lvm, e, u, lw, lmm);
        @(negedge clk);
        check("count", 32'(count), 32'(m_count));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("max_tick", 32'(max_tick), 32'(m_count == m_limit));
        check("min_tick", 32'(min_tick), 32'(m_count == 0));
        if (wrap) wrap_seen++;
    endtask

    initial begin
        // T1 reset held two cycles
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_max_tick", 32'(max_tick), 32'd0);
        check("rst_min_tick", 32'(min_tick), 32'd1);

        // T2 up counting through a wrap
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 1, 0, 0);

        // T3 down counting from a loaded zero
        cyc(1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 1, 0, 0, 0);

        // T4 limit shrink while stepping, then out-of-range recovery both ways
        cyc(1, 1, 7, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 1, 4);
        cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0, 0);

        // T5 load and lim_wr together, then reset overriding load
        cyc(1, 1, 3, 1, 1, 1, 2);
        cyc(0, 1, 5, 1, 1, 1, 7);

        // limit == 0: every step wraps, out-of-range values fold to 0
        cyc(1, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 5, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 5, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1, 0, 0);

        // full-range limit 2**N-1 wraps cleanly
        cyc(1, 1, 13, 0, 1, 1, 15);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 0, 0, 0);

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
        // T6 40 enabled cycles from reset give exactly one wrap
        cyc(0, 0, 0, 0, 1, 0, 0);
        wrap_seen = 0;
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1, 1, 0, 0);
        check("prescaled_wraps", 32'(wrap_seen), 32'd1);
        cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 2, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 1, 0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 50) != 0,
                ($urandom % 10) == 0,
                int'($urandom_range(0, 15)),
                ($urandom % 4) != 0,
                bit'($urandom % 2),
                ($urandom % 12) == 0,
                int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
